// File: rtl/lut_ram_pkg.sv
// Shared LUT-RAM definitions: address type and derived depth.
package lut_ram_pkg;

  localparam int LUT_ADDR_W = 5;
  localparam int LUT_DEPTH  = 2 ** LUT_ADDR_W;

  typedef logic [LUT_ADDR_W-1:0] lut_addr_t;

endpackage

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: architectural word type used across the core.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/lut_ram.sv
// Small distributed RAM: one synchronous write port, one combinational read
// port, every word cleared asynchronously by rst_n. Reads see the stored array
// only; write data is never forwarded, so a same-address read shows the old
// word until the write edge and the new word right after it.
module lut_ram
  import riscv_pkg::*;
  import lut_ram_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr_en,
  input  lut_addr_t wr_addr,
  input  word_t     wr_data,
  input  lut_addr_t rd_addr,
  output word_t     rd_data
);

  // The array is indexed directly by the full address, so depth and address
  // width must agree exactly; anything else is a configuration error.
  if (DEPTH != 2 ** $bits(lut_addr_t)) begin : g_depth_chk
    $error("lut_ram: DEPTH must equal 2**$bits(lut_addr_t)");
  end

  word_t mem_q [DEPTH];

  // Storage: asynchronous clear of every entry, otherwise one word per enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      assert (!$isunknown(rd_addr));
      if (wr_en) begin
        assert (!$isunknown(wr_addr));
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: tb/tb_lut_ram.sv
// Self-checking bench for lut_ram: directed scenarios plus randomized traffic
// compared against a plain array model of the memory.
module tb_lut_ram;
  import riscv_pkg::*;
  import lut_ram_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      wr_en;
  lut_addr_t wr_addr;
  word_t     wr_data;
  lut_addr_t rd_addr;
  word_t     rd_data;

  int checks;
  int errors;

  // Reference model: the memory contents as the bench believes them to be.
  word_t model [32];

  lut_ram #(.DEPTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Single write on the next rising edge; returns 1 ns after that edge.
  task automatic do_write(input int addr, input word_t data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = lut_addr_t'(addr);
    wr_data = data;
    @(posedge clk);
    if (rst_n) model[addr] = data;
    #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    // Put nonzero data in place so the clear is observable.
    do_write(0, 32'hCAFE_0000);
    do_write(17, 32'h1234_5678);
    do_write(31, 32'hFFFF_FFFF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    for (int a = 0; a < 32; a++) begin
      rd_addr = lut_addr_t'(a);
      #1;
      checks++;
      if (rd_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_sweep addr=%0d got=%h want=%h", a, rd_data, 32'h0);
      end
    end
    // Writes while held in reset are ignored.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9999_9999; rd_addr = 5'd9;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL write_in_reset got=%h want=%h", rd_data, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_readback();
    do_write(5, 32'hDEAD_BEEF);
    rd_addr = 5'd5;
    #1;
    checks++;
    if (rd_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL readback_a5 got=%h want=%h", rd_data, 32'hDEAD_BEEF);
    end
    rd_addr = 5'd4;
    #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL neighbour_a4 got=%h want=%h", rd_data, 32'h0);
    end
    rd_addr = 5'd6;
    #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL neighbour_a6 got=%h want=%h", rd_data, 32'h0);
    end
  endtask

  task automatic test_read_during_write();
    do_write(31, 32'h1111_1111);
    @(negedge clk);
    rd_addr = 5'd31;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h2222_2222;
    #1;
    checks++;
    if (rd_data !== 32'h1111_1111) begin
      errors++;
      $display("FAIL rdw_before got=%h want=%h", rd_data, 32'h1111_1111);
    end
    @(posedge clk);
    model[31] = 32'h2222_2222;
    #1;
    wr_en = 1'b0;
    checks++;
    if (rd_data !== 32'h2222_2222) begin
      errors++;
      $display("FAIL rdw_after got=%h want=%h", rd_data, 32'h2222_2222);
    end
  endtask

  task automatic test_write_disable();
    do_write(0, 32'h0BAD_F00D);
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr = 5'd0;
    @(posedge clk);
    #1;
    checks++;
    if (rd_data !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL write_disable got=%h want=%h", rd_data, 32'h0BAD_F00D);
    end
  endtask

  task automatic test_back_to_back();
    word_t exp;
    // Consecutive edges, wr_en held high throughout.
    @(negedge clk);
    wr_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wr_addr = lut_addr_t'(i);
      wr_data = word_t'(i) * 32'h0101_0101;
      @(posedge clk);
      model[i] = word_t'(i) * 32'h0101_0101;
      @(negedge clk);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = lut_addr_t'(i);
      #1;
      exp = word_t'(i) * 32'h0101_0101;
      checks++;
      if (rd_data !== exp || rd_data !== model[i]) begin
        errors++;
        $display("FAIL sweep addr=%0d got=%h want=%h", i, rd_data, exp);
      end
    end
    // Two writes to one address on adjacent edges: the later one stays.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hAAAA_0001;
    @(posedge clk);
    @(negedge clk);
    wr_data = 32'hBBBB_0002;
    @(posedge clk);
    model[12] = 32'hBBBB_0002;
    #1;
    wr_en = 1'b0;
    rd_addr = 5'd12;
    #1;
    checks++;
    if (rd_data !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL last_write_wins got=%h want=%h", rd_data, 32'hBBBB_0002);
    end
  endtask

  task automatic test_reset_mid_op();
    do_write(3, 32'hA5A5_A5A5);
    rd_addr = 5'd3;
    #1;
    checks++;
    if (rd_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL mid_pre got=%h want=%h", rd_data, 32'hA5A5_A5A5);
    end
    // Half-cycle pulse that does not straddle a rising edge.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_async_clear got=%h want=%h", rd_data, 32'h0);
    end
    #4;
    rst_n = 1'b1;
    do_write(3, 32'h0000_0077);
    checks++;
    if (rd_data !== 32'h0000_0077) begin
      errors++;
      $display("FAIL mid_post_write got=%h want=%h", rd_data, 32'h0000_0077);
    end
    // Reset spanning a write edge wins over the write.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h7777_7777; rd_addr = 5'd7;
    #2;
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_wins got=%h want=%h", rd_data, 32'h0);
    end
  endtask

  task automatic test_random();
    int a;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 3) != 0);
      wr_addr = lut_addr_t'($urandom_range(0, 31));
      wr_data = $urandom;
      a       = $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) a = int'(wr_addr);
      rd_addr = lut_addr_t'(a);
      #1;
      checks++;
      if (rd_data !== model[a]) begin
        errors++;
        $display("FAIL rand_pre n=%0d addr=%0d got=%h want=%h", n, a, rd_data, model[a]);
      end
      @(posedge clk);
      if (wr_en) model[wr_addr] = wr_data;
      #1;
      checks++;
      if (rd_data !== model[a]) begin
        errors++;
        $display("FAIL rand_post n=%0d addr=%0d got=%h want=%h", n, a, rd_data, model[a]);
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = lut_addr_t'(i);
      #1;
      checks++;
      if (rd_data !== model[i]) begin
        errors++;
        $display("FAIL rand_final addr=%0d got=%h want=%h", i, rd_data, model[i]);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_write_readback();
    test_read_during_write();
    test_write_disable();
    test_back_to_back();
    test_reset_mid_op();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
